decoder: RTL and testbench

- RV32I instruction decoder sitting between the fetch stage and the register file, ALU, immediate sign-extender and data memory.
- Splits a 32-bit instruction into register indices, funct fields, opcode, control strobes, ALU class, sign-extension class and a raw, unextended immediate.
- The decode path is combinational.
- One clocked status flag records whether an illegal instruction has been seen.

---
 rtl/decoder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// RV32I instruction decoder: field split, control strobes, ALU/extension class, raw immediate.
// Define DECODER_OUT_REG_EN to register every decode output, giving one cycle of latency.
module decoder #(
    parameter int DATA_WIDTH = 32,
    localparam int RW = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [6:0]            opcode,
    output logic [2:0]            f3,
    output logic [6:0]            f7,
    output logic [RW-1:0]         rs1,
    output logic [RW-1:0]         rs2,
    output logic [RW-1:0]         rd,
    output logic [2:0]            alu_op,
    output logic [2:0]            sx_op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [DATA_WIDTH-1:0] unextended_data,
    output logic                  illegal,
    output logic                  illegal_seen
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_R      = 3'b001;
    localparam logic [2:0] ALU_I      = 3'b010;
    localparam logic [2:0] ALU_BRANCH = 3'b011;
    localparam logic [2:0] ALU_LUI    = 3'b100;
    localparam logic [2:0] ALU_AUIPC  = 3'b101;
    localparam logic [2:0] ALU_INV    = 3'b111;

    localparam logic [2:0] SX_I12  = 3'b000;
    localparam logic [2:0] SX_B13  = 3'b010;
    localparam logic [2:0] SX_UPP  = 3'b011;
    localparam logic [2:0] SX_NONE = 3'b101;
    localparam logic [2:0] SX_J21  = 3'b110;
    localparam logic [2:0] SX_INV  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]            fld_opcode;
    logic [2:0]            fld_f3;
    logic [6:0]            fld_f7;
    logic [RW-1:0]         fld_rs1;
    logic [RW-1:0]         fld_rs2;
    logic [RW-1:0]         fld_rd;

    logic [6:0]            opcode_d;
    logic [2:0]            f3_d;
    logic [6:0]            f7_d;
    logic [RW-1:0]         rs1_d;
    logic [RW-1:0]         rs2_d;
    logic [RW-1:0]         rd_d;
    logic [2:0]            alu_op_d;
    logic [2:0]            sx_op_d;
    logic                  mem_read_d;
    logic                  mem_write_d;
    logic                  reg_write_d;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  illegal_d;
    logic                  valid;

    logic                  illegal_seen_d;
    logic                  illegal_seen_q;

    assign fld_opcode = instruction[6:0];
    assign fld_f3     = instruction[14:12];
    assign fld_f7     = instruction[31:25];
    assign fld_rs1    = instruction[19:15];
    assign fld_rs2    = instruction[24:20];
    assign fld_rd     = instruction[11:7];

    // Everything except opcode starts at the invalid pattern; a format only
    // overwrites it once its funct constraints have been met.
    always_comb begin
        opcode_d    = fld_opcode;
        f3_d        = '0;
        f7_d        = '0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        alu_op_d    = ALU_INV;
        sx_op_d     = SX_INV;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        imm_d       = '0;
        valid       = 1'b0;

        case (fld_opcode)
            OPC_LOAD: begin
                if (fld_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    valid        = 1'b1;
                    alu_op_d     = ALU_ADD;
                    sx_op_d      = SX_I12;
                    mem_read_d   = 1'b1;
                    reg_write_d  = 1'b1;
                    f3_d         = fld_f3;
                    rs1_d        = fld_rs1;
                    rd_d         = fld_rd;
                    imm_d[11:0]  = instruction[31:20];
                end
            end
            OPC_STORE: begin
                if (fld_f3 inside {3'b000, 3'b001, 3'b010}) begin
                    valid        = 1'b1;
                    alu_op_d     = ALU_ADD;
                    sx_op_d      = SX_I12;
                    mem_write_d  = 1'b1;
                    f3_d         = fld_f3;
                    rs1_d        = fld_rs1;
                    rs2_d        = fld_rs2;
                    imm_d[11:0]  = {instruction[31:25], instruction[11:7]};
                end
            end
            OPC_JAL: begin
                valid        = 1'b1;
                alu_op_d     = ALU_ADD;
                sx_op_d      = SX_J21;
                reg_write_d  = 1'b1;
                rd_d         = fld_rd;
                imm_d[20:0]  = {instruction[31], instruction[19:12], instruction[20],
                                instruction[30:21], 1'b0};
            end
            OPC_JALR: begin
                if (fld_f3 == 3'b000) begin
                    valid        = 1'b1;
                    alu_op_d     = ALU_ADD;
                    sx_op_d      = SX_I12;
                    reg_write_d  = 1'b1;
                    f3_d         = fld_f3;
                    rs1_d        = fld_rs1;
                    rd_d         = fld_rd;
                    imm_d[11:0]  = instruction[31:20];
                end
            end
            OPC_BRANCH: begin
                if (!(fld_f3 inside {3'b010, 3'b011})) begin
                    valid        = 1'b1;
                    alu_op_d     = ALU_BRANCH;
                    sx_op_d      = SX_B13;
                    f3_d         = fld_f3;
                    rs1_d        = fld_rs1;
                    rs2_d        = fld_rs2;
                    imm_d[12:0]  = {instruction[31], instruction[7], instruction[30:25],
                                    instruction[11:8], 1'b0};
                end
            end
            OPC_OP_IMM: begin
                // Shifts carry funct7 in the upper immediate bits and must check it.
                if ((fld_f3 == 3'b001 && fld_f7 == F7_BASE) ||
                    (fld_f3 == 3'b101 && (fld_f7 == F7_BASE || fld_f7 == F7_ALT)) ||
                    (fld_f3 != 3'b001 && fld_f3 != 3'b101)) begin
                    valid        = 1'b1;
                    alu_op_d     = ALU_I;
                    sx_op_d      = SX_I12;
                    reg_write_d  = 1'b1;
                    f3_d         = fld_f3;
                    rs1_d        = fld_rs1;
                    rd_d         = fld_rd;
                    imm_d[11:0]  = instruction[31:20];
                    if (fld_f3 == 3'b001 || fld_f3 == 3'b101) begin
                        f7_d = fld_f7;
                    end
                end
            end
            OPC_OP: begin
                if (fld_f7 == F7_BASE ||
                    (fld_f7 == F7_ALT && (fld_f3 == 3'b000 || fld_f3 == 3'b101))) begin
                    valid        = 1'b1;
                    alu_op_d     = ALU_R;
                    sx_op_d      = SX_NONE;
                    reg_write_d  = 1'b1;
                    f3_d         = fld_f3;
                    f7_d         = fld_f7;
                    rs1_d        = fld_rs1;
                    rs2_d        = fld_rs2;
                    rd_d         = fld_rd;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                valid        = 1'b1;
                alu_op_d     = (fld_opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
                sx_op_d      = SX_UPP;
                reg_write_d  = 1'b1;
                rd_d         = fld_rd;
                imm_d[19:0]  = instruction[31:12];
            end
            default: begin
                valid = 1'b0;
            end
        endcase

        illegal_d = !valid;
    end

`ifdef DECODER_OUT_REG_EN
    logic [6:0]            opcode_q;
    logic [2:0]            f3_q;
    logic [6:0]            f7_q;
    logic [RW-1:0]         rs1_q;
    logic [RW-1:0]         rs2_q;
    logic [RW-1:0]         rd_q;
    logic [2:0]            alu_op_q;
    logic [2:0]            sx_op_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  reg_write_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  illegal_q;

    // Reset loads the invalid pattern with opcode cleared rather than raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q    <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= ALU_INV;
            sx_op_q     <= SX_INV;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            f3_q        <= f3_d;
            f7_q        <= f7_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            sx_op_q     <= sx_op_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign opcode          = opcode_q;
    assign f3              = f3_q;
    assign f7              = f7_q;
    assign rs1             = rs1_q;
    assign rs2             = rs2_q;
    assign rd              = rd_q;
    assign alu_op          = alu_op_q;
    assign sx_op           = sx_op_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign reg_write       = reg_write_q;
    assign unextended_data = imm_q;
    assign illegal         = illegal_q;
`else
    assign opcode          = opcode_d;
    assign f3              = f3_d;
    assign f7              = f7_d;
    assign rs1             = rs1_d;
    assign rs2             = rs2_d;
    assign rd              = rd_d;
    assign alu_op          = alu_op_d;
    assign sx_op           = sx_op_d;
    assign mem_read        = mem_read_d;
    assign mem_write       = mem_write_d;
    assign reg_write       = reg_write_d;
    assign unextended_data = imm_d;
    assign illegal         = illegal_d;
`endif

    // Sticky flag follows whichever illegal is presented on the port.
    always_comb begin
        illegal_seen_d = illegal_seen_q | illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the RV32I decoder: hand-decoded expectations queued on drive, compared on sample.
module tb_decoder;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic [2:0]  sx_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

`ifdef DECODER_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu_op, sx_op;
    logic        mem_read, mem_write, reg_write;
    logic [31:0] unextended_data;
    logic        illegal, illegal_seen;

    int checks = 0;
    int failures = 0;
    dec_t exp_q[$];

    always #5 clk = ~clk;

    decoder #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .opcode(opcode), .f3(f3), .f7(f7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_op(alu_op), .sx_op(sx_op), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .unextended_data(unextended_data),
        .illegal(illegal), .illegal_seen(illegal_seen)
    );

    function automatic dec_t observe();
        return '{opcode, f3, f7, rs1, rs2, rd, alu_op, sx_op,
                 mem_read, mem_write, reg_write, unextended_data, illegal};
    endfunction

    function automatic dec_t ok(logic [6:0] op, logic [2:0] fn3, logic [6:0] fn7,
                                logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                                logic [2:0] alu, logic [2:0] sx,
                                logic mr, logic mw, logic rw, logic [31:0] imm);
        return '{op, fn3, fn7, s1, s2, d, alu, sx, mr, mw, rw, imm, 1'b0};
    endfunction

    function automatic dec_t bad(logic [6:0] op);
        return '{op, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        instruction = 32'h00252283;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (illegal_seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_seen got=%b exp=0", illegal_seen);
        end
        checks++;
        if (mem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_write got=%b exp=0", mem_write);
        end
        $display("txn reset illegal_seen=%b", illegal_seen);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mem_jump();
        logic [31:0] w [5];
        dec_t e [5];
        dec_t got, exp_v;
        w[0] = 32'h00252283; e[0] = ok(7'h03, 3'd2, 7'd0, 5'd10, 5'd0,  5'd5, 3'd0, 3'd0, 1, 0, 1, 32'h2);
        w[1] = 32'hFEA79123; e[1] = ok(7'h23, 3'd1, 7'd0, 5'd15, 5'd10, 5'd0, 3'd0, 3'd0, 0, 1, 0, 32'hFE2);
        w[2] = 32'h002000EF; e[2] = ok(7'h6F, 3'd0, 7'd0, 5'd0,  5'd0,  5'd1, 3'd0, 3'd6, 0, 0, 1, 32'h2);
        w[3] = 32'h001481E7; e[3] = ok(7'h67, 3'd0, 7'd0, 5'd9,  5'd0,  5'd3, 3'd0, 3'd0, 0, 0, 1, 32'h1);
        w[4] = 32'h00001067; e[4] = bad(7'h67);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instruction = w[i];
            exp_q.push_back(e[i]);
            @(posedge clk);
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL mem_jump instr=%h got=%h exp=%h", w[i], got, exp_v);
            end else $display("txn mem_jump instr=%h alu=%0d sx=%0d", w[i], alu_op, sx_op);
        end
    endtask

    task automatic test_alu_formats();
        logic [31:0] w [12];
        dec_t e [12];
        dec_t got, exp_v;
        w[0]  = 32'h002081B3; e[0]  = ok(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 3'd1, 3'd5, 0, 0, 1, 32'h0);
        w[1]  = 32'h022081B3; e[1]  = bad(7'h33);
        w[2]  = 32'h402081B3; e[2]  = ok(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 3'd1, 3'd5, 0, 0, 1, 32'h0);
        w[3]  = 32'h402091B3; e[3]  = bad(7'h33);
        w[4]  = 32'hFFF10093; e[4]  = ok(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 3'd2, 3'd0, 0, 0, 1, 32'hFFF);
        w[5]  = 32'h4032D213; e[5]  = ok(7'h13, 3'd5, 7'h20, 5'd5, 5'd0, 5'd4, 3'd2, 3'd0, 0, 0, 1, 32'h403);
        w[6]  = 32'h40101093; e[6]  = bad(7'h13);
        w[7]  = 32'h00208463; e[7]  = ok(7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 3'd3, 3'd2, 0, 0, 0, 32'h8);
        w[8]  = 32'hFE001EE3; e[8]  = ok(7'h63, 3'd1, 7'h00, 5'd0, 5'd0, 5'd0, 3'd3, 3'd2, 0, 0, 0, 32'h1FFC);
        w[9]  = 32'h00002063; e[9]  = bad(7'h63);
        w[10] = 32'hABCDE2B7; e[10] = ok(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 3'd4, 3'd3, 0, 0, 1, 32'hABCDE);
        w[11] = 32'h12345397; e[11] = ok(7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 3'd5, 3'd3, 0, 0, 1, 32'h12345);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            instruction = w[i];
            exp_q.push_back(e[i]);
            @(posedge clk);
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL alu_formats instr=%h got=%h exp=%h", w[i], got, exp_v);
            end else $display("txn alu_formats instr=%h alu=%0d sx=%0d", w[i], alu_op, sx_op);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w [5];
        dec_t e [5];
        dec_t got, exp_v;
        w[0] = 32'hFFFFFFFF; e[0] = bad(7'h7F);
        w[1] = 32'h00000000; e[1] = bad(7'h00);
        w[2] = 32'h00003003; e[2] = bad(7'h03);
        w[3] = 32'h00003023; e[3] = bad(7'h23);
        w[4] = 32'h0000007B; e[4] = bad(7'h7B);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instruction = w[i];
            exp_q.push_back(e[i]);
            @(posedge clk);
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL illegal instr=%h got=%h exp=%h", w[i], got, exp_v);
            end else $display("txn illegal instr=%h opcode=%h", w[i], opcode);
        end
    endtask

    task automatic test_sticky();
        @(negedge clk);
        rst = 1'b1;
        instruction = 32'h00252283;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        checks++;
        if (illegal_seen !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear got=%b exp=0", illegal_seen);
        end
        @(negedge clk);
        instruction = 32'hFFFFFFFF;
        repeat (LAT + 1) @(posedge clk);
        #1;
        checks++;
        if (illegal_seen !== 1'b1) begin
            failures++;
            $display("FAIL sticky_set got=%b exp=1", illegal_seen);
        end
        $display("txn sticky instr=ffffffff seen=%b", illegal_seen);
        @(negedge clk);
        instruction = 32'h002081B3;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if (illegal_seen !== 1'b1) begin
            failures++;
            $display("FAIL sticky_hold got=%b exp=1", illegal_seen);
        end
        $display("txn sticky instr=002081b3 seen=%b", illegal_seen);
        // rst must win over an illegal word presented on the same edge
        @(negedge clk);
        rst = 1'b1;
        instruction = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        checks++;
        if (illegal_seen !== 1'b0) begin
            failures++;
            $display("FAIL sticky_rst_priority got=%b exp=0", illegal_seen);
        end
        $display("txn sticky rst seen=%b", illegal_seen);
        @(negedge clk);
        instruction = 32'h00252283;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [6];
        dec_t e [6];
        dec_t got, exp_v;
        int k;
        w[0] = 32'h00252283; e[0] = ok(7'h03, 3'd2, 7'd0, 5'd10, 5'd0,  5'd5, 3'd0, 3'd0, 1, 0, 1, 32'h2);
        w[1] = 32'hFEA79123; e[1] = ok(7'h23, 3'd1, 7'd0, 5'd15, 5'd10, 5'd0, 3'd0, 3'd0, 0, 1, 0, 32'hFE2);
        w[2] = 32'h002081B3; e[2] = ok(7'h33, 3'd0, 7'd0, 5'd1,  5'd2,  5'd3, 3'd1, 3'd5, 0, 0, 1, 32'h0);
        w[3] = 32'hFFFFFFFF; e[3] = bad(7'h7F);
        w[4] = 32'hABCDE2B7; e[4] = ok(7'h37, 3'd0, 7'd0, 5'd0,  5'd0,  5'd5, 3'd4, 3'd3, 0, 0, 1, 32'hABCDE);
        w[5] = 32'hFE001EE3; e[5] = ok(7'h63, 3'd1, 7'd0, 5'd0,  5'd0,  5'd0, 3'd3, 3'd2, 0, 0, 0, 32'h1FFC);
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(5, 0);
            @(negedge clk);
            instruction = w[k];
            exp_q.push_back(e[k]);
            @(posedge clk);
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL back_to_back instr=%h got=%h exp=%h", w[k], got, exp_v);
            end else $display("txn back_to_back instr=%h alu=%0d", w[k], alu_op);
        end
    endtask

    initial begin
        test_reset();
        test_mem_jump();
        test_alu_formats();
        test_illegal();
        test_sticky();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
